// File: rtl/servo_pkg.sv
// Shared defaults and FSM encoding for the servo PWM generator.
// Timing defaults assume a 100 MHz clock and a 50 Hz servo frame.
package servo_pkg;

  localparam int DEF_CANT_BITS   = 13;
  localparam int DEF_CNT_W       = 21;
  localparam int DEF_PERIOD      = 2000000;
  localparam int DEF_DUTY_MIN    = 100000;
  localparam int DEF_DUTY_MAX    = 200000;
  localparam int DEF_DUTY_CENTER = 150000;
  localparam int DEF_SHIFT       = 6;
  localparam int DEF_SLEW_STEP   = 2000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    CLAMP = 2'd2
  } state_e;

endpackage

// File: rtl/servo_pwm_gen_pwm_counter.sv
// Period counter, wrap tick, duty latch and registered PWM output.
// With PWM_SLEW_LIMIT_EN the duty moves toward the pending value in bounded steps.
module pwm_counter
  import servo_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PERIOD      = DEF_PERIOD,
  parameter int DUTY_CENTER = DEF_DUTY_CENTER
`ifdef PWM_SLEW_LIMIT_EN
  ,
  parameter int DUTY_MIN    = DEF_DUTY_MIN,
  parameter int DUTY_MAX    = DEF_DUTY_MAX,
  parameter int SLEW_STEP   = DEF_SLEW_STEP
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] duty_pend_i,
  output logic             pwm_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] duty_act_o
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CENTER = CNT_W'(DUTY_CENTER);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic [CNT_W-1:0] next_duty;

  assign wrap = en_i && (cnt_q == LAST);

`ifdef PWM_SLEW_LIMIT_EN
  localparam int W1 = CNT_W + 1;
  localparam logic [CNT_W:0] STEP  = W1'(SLEW_STEP);
  localparam logic [CNT_W:0] MIN_W = W1'(DUTY_MIN);
  localparam logic [CNT_W:0] MAX_W = W1'(DUTY_MAX);

  logic [CNT_W:0] act_w;
  logic [CNT_W:0] pend_w;
  logic [CNT_W:0] slew_w;

  always_comb begin
    act_w  = {1'b0, duty_q};
    pend_w = {1'b0, duty_pend_i};
    slew_w = pend_w;
    if (pend_w > act_w + STEP) begin
      slew_w = act_w + STEP;
    end else if (pend_w + STEP < act_w) begin
      slew_w = act_w - STEP;
    end
    if (slew_w > MAX_W) begin
      slew_w = MAX_W;
    end else if (slew_w < MIN_W) begin
      slew_w = MIN_W;
    end
    next_duty = slew_w[CNT_W-1:0];
  end
`else
  assign next_duty = duty_pend_i;
`endif

  always_comb begin
    cnt_d  = '0;
    duty_d = duty_q;
    tick_d = 1'b0;
    pwm_d  = en_i && (cnt_q < duty_q);
    if (en_i) begin
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      tick_d = wrap;
      if (wrap) begin
        duty_d = next_duty;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      duty_q <= CENTER;
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      tick_q <= tick_d;
    end
  end

  assign pwm_o      = pwm_q;
  assign tick_o     = tick_q;
  assign duty_act_o = duty_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: scales/clamps controller effort Yk into a pulse width.
// Optional build macro PWM_SLEW_LIMIT_EN limits duty change per period.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CANT_BITS   = DEF_CANT_BITS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PERIOD      = DEF_PERIOD,
  parameter int DUTY_MIN    = DEF_DUTY_MIN,
  parameter int DUTY_MAX    = DEF_DUTY_MAX,
  parameter int DUTY_CENTER = DEF_DUTY_CENTER,
  parameter int SHIFT       = DEF_SHIFT
`ifdef PWM_SLEW_LIMIT_EN
  ,
  parameter int SLEW_STEP   = DEF_SLEW_STEP
`endif
) (
  input  logic                   Clk_G,
  input  logic                   Rst_G,
  input  logic                   En,
  input  logic [2*CANT_BITS-1:0] Yk,
  input  logic                   Yk_Vld,
  output logic                   Busy,
  output logic                   Pwm_Out,
  output logic                   Sample_Tick,
  output logic                   Sat_Hi,
  output logic                   Sat_Lo,
  output logic [CNT_W-1:0]       Duty_Act
);

  localparam int YW = 2 * CANT_BITS;
  localparam int SW = YW + 2;

  localparam logic signed [SW-1:0] CENTER_S = SW'(DUTY_CENTER);
  localparam logic signed [SW-1:0] MIN_S    = SW'(DUTY_MIN);
  localparam logic signed [SW-1:0] MAX_S    = SW'(DUTY_MAX);

  state_e                 state_q, state_d;
  logic signed [YW-1:0]   yk_q, yk_d;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]       pend_q, pend_d;
  logic                   sat_hi_q, sat_hi_d;
  logic                   sat_lo_q, sat_lo_d;
  logic signed [SW-1:0]   yk_ext;

  // Sign-extend before the shift so the floor behaviour holds for negatives.
  assign yk_ext = SW'(yk_q);

  always_comb begin
    state_d  = state_q;
    yk_d     = yk_q;
    sum_d    = sum_q;
    pend_d   = pend_q;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    unique case (state_q)
      IDLE: begin
        if (Yk_Vld) begin
          yk_d    = Yk;
          state_d = SCALE;
        end
      end
      SCALE: begin
        sum_d   = (yk_ext >>> SHIFT) + CENTER_S;
        state_d = CLAMP;
      end
      CLAMP: begin
        state_d = IDLE;
        if (sum_q > MAX_S) begin
          pend_d   = CNT_W'(DUTY_MAX);
          sat_hi_d = 1'b1;
          sat_lo_d = 1'b0;
        end else if (sum_q < MIN_S) begin
          pend_d   = CNT_W'(DUTY_MIN);
          sat_hi_d = 1'b0;
          sat_lo_d = 1'b1;
        end else begin
          pend_d   = sum_q[CNT_W-1:0];
          sat_hi_d = 1'b0;
          sat_lo_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_G) begin
    if (!Rst_G) begin
      state_q  <= IDLE;
      yk_q     <= '0;
      sum_q    <= '0;
      pend_q   <= CNT_W'(DUTY_CENTER);
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      yk_q     <= yk_d;
      sum_q    <= sum_d;
      pend_q   <= pend_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  pwm_counter #(
    .CNT_W       (CNT_W),
    .PERIOD      (PERIOD),
    .DUTY_CENTER (DUTY_CENTER)
`ifdef PWM_SLEW_LIMIT_EN
    ,
    .DUTY_MIN    (DUTY_MIN),
    .DUTY_MAX    (DUTY_MAX),
    .SLEW_STEP   (SLEW_STEP)
`endif
  ) u_cnt (
    .clk_i       (Clk_G),
    .rst_n_i     (Rst_G),
    .en_i        (En),
    .duty_pend_i (pend_q),
    .pwm_o       (Pwm_Out),
    .tick_o      (Sample_Tick),
    .duty_act_o  (Duty_Act)
  );

  assign Busy   = (state_q != IDLE);
  assign Sat_Hi = sat_hi_q;
  assign Sat_Lo = sat_lo_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen with a small-period configuration.
// Expected per-period duty and flags come from an arithmetic model.
module tb_servo_pwm_gen;

  localparam int P    = 100;
  localparam int DMIN = 20;
  localparam int DMAX = 80;
  localparam int DC   = 50;
  localparam int SH   = 2;
  localparam int STEP = 5;

  logic        clk = 1'b0;
  logic        rst_n, en, yk_vld;
  logic [25:0] yk;
  logic        busy, pwm, tick, sat_hi, sat_lo;
  logic [20:0] duty_act;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CANT_BITS   (13),
    .CNT_W       (21),
    .PERIOD      (P),
    .DUTY_MIN    (DMIN),
    .DUTY_MAX    (DMAX),
    .DUTY_CENTER (DC),
    .SHIFT       (SH)
`ifdef PWM_SLEW_LIMIT_EN
    ,
    .SLEW_STEP   (STEP)
`endif
  ) dut (
    .Clk_G       (clk),
    .Rst_G       (rst_n),
    .En          (en),
    .Yk          (yk),
    .Yk_Vld      (yk_vld),
    .Busy        (busy),
    .Pwm_Out     (pwm),
    .Sample_Tick (tick),
    .Sat_Hi      (sat_hi),
    .Sat_Lo      (sat_lo),
    .Duty_Act    (duty_act)
  );

  typedef struct {
    int duty;
    bit hi;
    bit lo;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pend_m = DC;
  int   act_m  = DC;
  bit   hi_m   = 1'b0;
  bit   lo_m   = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div(input int y, input int d);
    if (y >= 0) return y / d;
    return -((-y + d - 1) / d);
  endfunction

  task automatic model_sample(input int y);
    int s;
    s = floor_div(y, 1 << SH) + DC;
    hi_m = (s > DMAX);
    lo_m = (s < DMIN);
    pend_m = hi_m ? DMAX : (lo_m ? DMIN : s);
  endtask

  function automatic int model_wrap(input int a, input int p);
`ifdef PWM_SLEW_LIMIT_EN
    int n;
    n = p;
    if (p > a + STEP) n = a + STEP;
    else if (p < a - STEP) n = a - STEP;
    if (n > DMAX) n = DMAX;
    if (n < DMIN) n = DMIN;
    return n;
`else
    return p;
`endif
  endfunction

  task automatic end_period();
    act_m = model_wrap(act_m, pend_m);
    sbq.push_back('{duty: act_m, hi: hi_m, lo: lo_m});
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick && k < 3 * P);
    if (!tick) chk("tick_seen", int'(tick), 1);
  endtask

  // Strobe at a negedge; optional second strobe lands while busy.
  task automatic send(input int y, input bit dbl);
    yk = 26'(y);
    yk_vld = 1'b1;
    @(negedge clk);
    chk("busy_scale", int'(busy), 1);
    if (dbl) yk = 26'(y + 1000);
    else yk_vld = 1'b0;
    @(negedge clk);
    yk_vld = 1'b0;
    chk("busy_clamp", int'(busy), 1);
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
    model_sample(y);
    chk("sat_hi_now", int'(sat_hi), int'(hi_m));
    chk("sat_lo_now", int'(sat_lo), int'(lo_m));
  endtask

  task automatic dir(input int y, input bit dbl);
    wait_tick();
    repeat (10) @(negedge clk);
    send(y, dbl);
    end_period();
  endtask

  task automatic empty_periods(input int n);
    for (int i = 0; i < n; i++) begin
      wait_tick();
      end_period();
    end
  endtask

  int   hi_cnt = 0;
  int   prev_duty = 0;
  bit   have_prev = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!mon_en) begin
      hi_cnt = 0;
      have_prev = 1'b0;
    end else begin
      if (tick) begin
        if (have_prev) chk("pwm_high_cnt", hi_cnt, prev_duty);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got tick with empty queue at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("duty_act", int'(duty_act), e.duty);
          chk("sat_hi", int'(sat_hi), int'(e.hi));
          chk("sat_lo", int'(sat_lo), int'(e.lo));
          prev_duty = e.duty;
          have_prev = 1'b1;
        end
        hi_cnt = 0;
      end
      if (pwm) hi_cnt++;
    end
  end

  initial begin
    int k;
    int nt;
    int np;
    logic [25:0] r26;
    rst_n = 1'b0;
    en = 1'b0;
    yk_vld = 1'b0;
    yk = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_duty", int'(duty_act), DC);
    chk("rst_sat_hi", int'(sat_hi), 0);
    chk("rst_sat_lo", int'(sat_lo), 0);
    rst_n = 1'b1;
    en = 1'b1;
    sbq.push_back('{duty: DC, hi: 1'b0, lo: 1'b0});
    mon_en = 1'b1;

    empty_periods(2);
    dir(40, 1'b0);
    empty_periods(1);
    dir(400, 1'b0);
    empty_periods(7);
    dir(-400, 1'b0);
    empty_periods(13);
    dir(-3, 1'b0);
    empty_periods(7);
    dir(40, 1'b1);
    empty_periods(3);

    for (int p = 0; p < 40; p++) begin
      wait_tick();
      k = $urandom_range(0, 3);
      for (int s = 0; s < k; s++) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
          r26 = 26'($urandom);
          send(int'($signed(r26)), $urandom_range(0, 3) == 0);
        end else begin
          send(int'($urandom_range(0, 600)) - 300, $urandom_range(0, 3) == 0);
        end
      end
      end_period();
    end

    dir(40, 1'b0);
    empty_periods(13);
    wait_tick();
    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained", sbq.size(), 0);

    // Enable low: output idle, no ticks, duty retained.
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("en_off_pwm", int'(pwm), 0);
    nt = 0;
    np = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tick) nt++;
      if (pwm) np++;
    end
    chk("en_off_ticks", nt, 0);
    chk("en_off_highs", np, 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_on_duty", int'(duty_act), act_m);

    // Reset mid-period with a sample in flight.
    wait_tick();
    repeat (30) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm), 1);
    yk = 26'(400);
    yk_vld = 1'b1;
    @(negedge clk);
    yk_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_pwm", int'(pwm), 0);
    chk("post_rst_duty", int'(duty_act), DC);
    chk("post_rst_busy", int'(busy), 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick && k < 3 * P);
    chk("post_rst_tick_dist", k, P);
    chk("post_rst_duty_wrap", int'(duty_act), DC);
    chk("post_rst_sat_hi", int'(sat_hi), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
